// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit that sits after the ALU in the execute stage.
// It makes one data-memory access per request over a req/gnt/rvalid bus. Load
// data is returned sign- or zero-extended, and a store returns a completion pulse.
// Optional build macro: LSU_MISALIGN_ALIGN_EN. When it is defined, a misaligned
// address is aligned down and the access goes ahead. It is not treated as an error.
module lsu_unit #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [3:0]      lsu_op_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_data_o,
    output logic            lsu_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RWAIT = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;

    logic [1:0]       acc_size;
    logic [1:0]       acc_lane;
    logic             acc_misalign;
    logic             acc_legal;

    // Only the eight RV32 load/store encodings are accepted.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Byte-enable pattern for the access size and byte lane.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Copy the store operand into every lane so that the byte enables choose the lane.
    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size,
                                                   input logic [XLEN-1:0] rs2);
        case (size)
            2'b00:   return {(XLEN/8){rs2[7:0]}};
            2'b01:   return {(XLEN/16){rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    // Pick the addressed byte or halfword out of the read word, then extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3,
                                                    input logic [1:0] lane,
                                                    input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return rdata;
        endcase
    endfunction

    assign acc_size  = lsu_op_i[1:0];
    assign acc_legal = op_legal(lsu_op_i);

`ifdef LSU_MISALIGN_ALIGN_EN
    // Align down: halfword accesses drop addr[0], word accesses drop addr[1:0].
    assign acc_lane     = (acc_size == 2'b10) ? 2'b00 :
                          (acc_size == 2'b01) ? {alu_out_i[1], 1'b0} : alu_out_i[1:0];
    assign acc_misalign = 1'b0;
`else
    assign acc_lane     = alu_out_i[1:0];
    assign acc_misalign = ((acc_size == 2'b01) && alu_out_i[0]) ||
                          ((acc_size == 2'b10) && (alu_out_i[1:0] != 2'b00));
`endif

    // Access FSM. Every output is registered so that the bus and the result stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            is_store_q     <= 1'b0;
            funct3_q       <= 3'b000;
            lane_q         <= 2'b00;
            lsu_ready_o    <= 1'b1;
            result_valid_o <= 1'b0;
            result_data_o  <= '0;
            lsu_err_o      <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_be_o       <= 4'b0000;
            mem_wdata_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_valid_i && lsu_ready_o) begin
                        lsu_ready_o <= 1'b0;
                        is_store_q  <= lsu_op_i[3];
                        funct3_q    <= lsu_op_i[2:0];
                        lane_q      <= acc_lane;
                        if (!acc_legal || acc_misalign) begin
                            // A rejected request never reaches the bus.
                            state          <= ERR;
                            result_valid_o <= 1'b1;
                            lsu_err_o      <= 1'b1;
                            result_data_o  <= '0;
                        end else begin
                            state       <= REQ;
                            wait_cnt    <= '0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= lsu_op_i[3];
                            mem_addr_o  <= {alu_out_i[XLEN-1:2], 2'b00};
                            mem_be_o    <= byte_en(acc_size, acc_lane);
                            mem_wdata_o <= store_data(acc_size, rs2_data_i);
                        end
                    end
                end
                REQ: begin
                    // A grant has priority over a timeout that falls in the same cycle.
                    // An rvalid seen here is ignored.
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_be_o  <= 4'b0000;
                        wait_cnt  <= '0;
                        if (is_store_q) begin
                            state          <= DONE;
                            result_valid_o <= 1'b1;
                            result_data_o  <= '0;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req_o      <= 1'b0;
                        mem_we_o       <= 1'b0;
                        mem_be_o       <= 4'b0000;
                        state          <= ERR;
                        result_valid_o <= 1'b1;
                        lsu_err_o      <= 1'b1;
                        result_data_o  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RWAIT: begin
                    if (mem_rvalid_i) begin
                        state          <= DONE;
                        result_valid_o <= 1'b1;
                        result_data_o  <= load_extend(funct3_q, lane_q, mem_rdata_i);
                    end else if (wait_cnt == CNT_LAST) begin
                        // After this abort, a late rvalid is ignored because the unit is back in IDLE.
                        state          <= ERR;
                        result_valid_o <= 1'b1;
                        lsu_err_o      <= 1'b1;
                        result_data_o  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    // One-cycle pulse. result_data_o keeps its value until the next completion.
                    state          <= IDLE;
                    result_valid_o <= 1'b0;
                    lsu_err_o      <= 1'b0;
                    lsu_ready_o    <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    result_valid_o <= 1'b0;
                    lsu_err_o      <= 1'b0;
                    lsu_ready_o    <= 1'b1;
                    mem_req_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed testbench for lsu_unit. The DUT is built with MAX_WAIT=4 so the
// timeout path is short. Inputs change on the falling edge and outputs are sampled there too.
module tb_lsu_unit;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_op;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        result_valid;
    logic [31:0] result_data;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    lsu_unit #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready),
        .lsu_op_i       (lsu_op),
        .alu_out_i      (alu_out),
        .rs2_data_i     (rs2_data),
        .result_valid_o (result_valid),
        .result_data_o  (result_data),
        .lsu_err_o      (lsu_err),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", result_valid); end
        total++; if (lsu_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", lsu_err); end
        total++; if (result_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", result_data); end
    endtask

    task automatic test_store_word();
        // The request is accepted at the next rising edge. The grant is already high, so it is taken in the first REQ cycle.
        lsu_valid = 1'b1; lsu_op = 4'd10; alu_out = 32'h0000_1000; rs2_data = 32'hDEAD_BEEF; mem_gnt = 1'b1;
        @(negedge clk);
        lsu_valid = 1'b0; alu_out = 32'hFFFF_FFFF; rs2_data = 32'h0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL sw_req: got %b want 1", mem_req); end
        total++; if (mem_be !== 4'b1111) begin bad++; $display("FAIL sw_be: got %b want 1111", mem_be); end
        total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sw_addr: got %h want 00001000", mem_addr); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sw_we: got %b want 1", mem_we); end
        total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
        total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL sw_busy: got %b want 0", lsu_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL sw_early: got %b want 0", result_valid); end
        @(negedge clk);
        mem_gnt = 1'b0;
        // This is the second cycle after accept, so the completion pulse must be high here.
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL sw_done: got %b want 1", result_valid); end
        total++; if (lsu_err !== 1'b0) begin bad++; $display("FAIL sw_err: got %b want 0", lsu_err); end
        total++; if (result_data !== 32'h0) begin bad++; $display("FAIL sw_data: got %h want 0", result_data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sw_req_drop: got %b want 0", mem_req); end
        @(negedge clk);
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL sw_pulse: got %b want 0", result_valid); end
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL sw_idle: got %b want 1", lsu_ready); end
    endtask

    task automatic test_sub_word_loads();
        logic [3:0]  op  [6] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd0};
        logic [31:0] adr [6] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2000, 32'h2001};
        logic [31:0] rd  [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234,
                                 32'h1234_5678, 32'h0000_7F00};
        logic [3:0]  be  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                 32'h1234_5678, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            lsu_valid = 1'b1; lsu_op = op[i]; alu_out = adr[i]; rs2_data = 32'h0;
            @(negedge clk);
            lsu_valid = 1'b0; alu_out = 32'h0;
            total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL ld%0d_req: got req=%b we=%b want req=1 we=0", i, mem_req, mem_we); end
            total++; if (mem_be !== be[i]) begin bad++; $display("FAIL ld%0d_be: got %b want %b", i, mem_be, be[i]); end
            total++; if (mem_addr !== 32'h2000) begin bad++; $display("FAIL ld%0d_addr: got %h want 00002000", i, mem_addr); end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd[i];
            total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ld%0d_early: got %b want 0", i, result_valid); end
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
            total++; if (result_valid !== 1'b1 || lsu_err !== 1'b0) begin bad++; $display("FAIL ld%0d_done: got v=%b e=%b want v=1 e=0", i, result_valid, lsu_err); end
            total++; if (result_data !== exp[i]) begin bad++; $display("FAIL ld%0d_data: got %h want %h", i, result_data, exp[i]); end
            @(negedge clk);
            total++; if (result_valid !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL ld%0d_idle: got v=%b rdy=%b want v=0 rdy=1", i, result_valid, lsu_ready); end
        end
    endtask

    task automatic test_misalign_illegal();
        logic [3:0] ill [3] = '{4'b0011, 4'b1011, 4'b1111};
        lsu_valid = 1'b1; lsu_op = 4'd2; alu_out = 32'h0000_3002;
        @(negedge clk);
        lsu_valid = 1'b0;
`ifdef LSU_MISALIGN_ALIGN_EN
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin bad++; $display("FAIL mis_align: got req=%b addr=%h want req=1 addr=00003000", mem_req, mem_addr); end
        total++; if (lsu_err !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL mis_noerr: got e=%b v=%b want 0 0", lsu_err, result_valid); end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++; if (result_valid !== 1'b1 || lsu_err !== 1'b0 || result_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_done: got v=%b e=%b d=%h want 1 0 cafef00d", result_valid, lsu_err, result_data); end
`else
        total++; if (result_valid !== 1'b1 || lsu_err !== 1'b1) begin bad++; $display("FAIL mis_err: got v=%b e=%b want 1 1", result_valid, lsu_err); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_nobus: got %b want 0", mem_req); end
        total++; if (result_data !== 32'h0) begin bad++; $display("FAIL mis_data: got %h want 0", result_data); end
`endif
        @(negedge clk);
        total++; if (result_valid !== 1'b0 || lsu_err !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL mis_idle: got v=%b e=%b rdy=%b want 0 0 1", result_valid, lsu_err, lsu_ready); end
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1'b1; lsu_op = ill[i]; alu_out = 32'h0000_3000;
            @(negedge clk);
            lsu_valid = 1'b0;
            total++; if (result_valid !== 1'b1 || lsu_err !== 1'b1) begin bad++; $display("FAIL ill%0d_err: got v=%b e=%b want 1 1", i, result_valid, lsu_err); end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ill%0d_nobus: got %b want 0", i, mem_req); end
            @(negedge clk);
            total++; if (lsu_err !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL ill%0d_idle: got e=%b rdy=%b want 0 1", i, lsu_err, lsu_ready); end
        end
    endtask

    task automatic test_timeout();
        lsu_valid = 1'b1; lsu_op = 4'd2; alu_out = 32'h0000_4000; mem_gnt = 1'b0;
        @(negedge clk);
        lsu_valid = 1'b0;
        // The request stays on the bus for four REQ cycles, and then the unit aborts.
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_req !== 1'b1 || lsu_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d: got req=%b e=%b want 1 0", i, mem_req, lsu_err); end
            @(negedge clk);
        end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL to_drop: got %b want 0", mem_req); end
        total++; if (lsu_err !== 1'b1 || result_valid !== 1'b1) begin bad++; $display("FAIL to_err: got e=%b v=%b want 1 1", lsu_err, result_valid); end
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        total++; if (result_valid !== 1'b0 || lsu_err !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL to_idle: got v=%b e=%b rdy=%b want 0 0 1", result_valid, lsu_err, lsu_ready); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL to_late: got %b want 0", result_valid); end
    endtask

    task automatic test_back_to_back();
        lsu_valid = 1'b1; lsu_op = 4'd8; alu_out = 32'h0000_0011; rs2_data = 32'h0000_00AB; mem_gnt = 1'b0;
        @(negedge clk);
        lsu_valid = 1'b0; rs2_data = 32'h0000_0055; alu_out = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_be !== 4'b0010 || mem_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL b2b_hold%0d: got be=%b wd=%h want 0010 abababab", i, mem_be, mem_wdata); end
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b1) begin bad++; $display("FAIL b2b_bus%0d: got req=%b addr=%h we=%b want 1 00000010 1", i, mem_req, mem_addr, mem_we); end
            total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy%0d: got %b want 0", i, lsu_ready); end
            if (i < 3) @(negedge clk);
        end
        // Grant after three ungranted cycles. The next request is already waiting.
        mem_gnt = 1'b1;
        lsu_valid = 1'b1; lsu_op = 4'd4; alu_out = 32'h0000_0022;
        @(negedge clk);
        mem_gnt = 1'b0;
        total++; if (result_valid !== 1'b1 || lsu_err !== 1'b0) begin bad++; $display("FAIL b2b_done: got v=%b e=%b want 1 0", result_valid, lsu_err); end
        total++; if (lsu_ready !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL b2b_noacc: got rdy=%b req=%b want 0 0", lsu_ready, mem_req); end
        @(negedge clk);
        total++; if (lsu_ready !== 1'b1 || mem_req !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got rdy=%b req=%b v=%b want 1 0 0", lsu_ready, mem_req, result_valid); end
        @(negedge clk);
        lsu_valid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20 || mem_be !== 4'b0100) begin bad++; $display("FAIL b2b_next: got req=%b we=%b addr=%h be=%b want 1 0 00000020 0100", mem_req, mem_we, mem_addr, mem_be); end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00F3_0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++; if (result_valid !== 1'b1 || result_data !== 32'h0000_00F3) begin bad++; $display("FAIL b2b_ld: got v=%b d=%h want 1 000000f3", result_valid, result_data); end
        @(negedge clk);
        total++; if (result_data !== 32'h0000_00F3 || result_valid !== 1'b0) begin bad++; $display("FAIL b2b_hold_data: got v=%b d=%h want 0 000000f3", result_valid, result_data); end
    endtask

    task automatic test_reset_mid_access();
        lsu_valid = 1'b1; lsu_op = 4'd2; alu_out = 32'h0000_5004;
        @(negedge clk);
        lsu_valid = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_req_pre: got %b want 1", mem_req); end
        #2 rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL rst_req_async: got req=%b rdy=%b want 0 1", mem_req, lsu_ready); end
        @(negedge clk);
        rst = 1'b0;
        lsu_valid = 1'b1; lsu_op = 4'd2; alu_out = 32'h0000_5008;
        @(negedge clk);
        lsu_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total++; if (lsu_ready !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_rwait: got rdy=%b req=%b want 0 0", lsu_ready, mem_req); end
        #2 rst = 1'b1;
        #1;
        total++; if (lsu_ready !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_rwait_async: got rdy=%b req=%b want 1 0", lsu_ready, mem_req); end
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        total++; if (result_valid !== 1'b0 || lsu_ready !== 1'b1) begin bad++; $display("FAIL rst_late1: got v=%b rdy=%b want 0 1", result_valid, lsu_ready); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++; if (result_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_late2: got v=%b req=%b want 0 0", result_valid, mem_req); end
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; lsu_op = 4'd0; alu_out = 32'h0; rs2_data = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_sub_word_loads();
        test_misalign_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
